// File: rtl/line_fill_pkg.sv
// rtl/line_fill_pkg.sv - shared types and constants for the line fill controller
package line_fill_pkg;

  localparam int WORD_BYTES       = 4;
  localparam int LINE_WORDS       = 4;
  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/line_fill_ctrl.sv
// rtl/line_fill_ctrl.sv - fetches one aligned cache line word by word and feeds the line shift register
module line_fill_ctrl
  import line_fill_pkg::*;
#(
  parameter int LINE_WORDS = line_fill_pkg::LINE_WORDS,
  parameter int ADDR_W     = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              shift_in,
  output logic [31:0]       word_out
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);
  localparam logic [1:0]        LAST_BEAT = 2'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              beat_complete;
  logic              shift_q;
  logic [31:0]       word_q;

  // State, beat counter and line base register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  // Next-state logic; a grant with same-cycle rvalid completes the beat without visiting WAIT
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    base_d        = base_q;
    beat_complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_req) begin
          base_d  = fill_addr & ~LINE_MASK;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt && mem_rvalid) begin
          beat_complete = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DRAIN;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          beat_complete = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DRAIN;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = REQ;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered shift strobe and data; word_out keeps the last captured word between pulses
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      shift_q <= 1'b0;
      word_q  <= '0;
    end else begin
      shift_q <= beat_complete;
      if (beat_complete) begin
        word_q <= mem_rdata;
      end
    end
  end

  assign fill_busy = (state_q != IDLE);
  assign fill_done = (state_q == DONE);
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = (state_q == REQ) ? base_q + ADDR_W'(beat_q) * ADDR_W'(WORD_BYTES) : '0;
  assign shift_in  = shift_q;
  assign word_out  = word_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb/tb_line_fill_ctrl.sv - directed self-checking bench for line_fill_ctrl
module tb_line_fill_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic        fill_busy;
  logic        fill_done;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        shift_in;
  logic [31:0] word_out;

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           shifts;
  int           last_rv;
  int           done_cyc;
  int           req_cyc;
  logic [127:0] line;
  logic [31:0]  exp_w [4];

  always #5 Clk = ~Clk;

  line_fill_ctrl #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .fill_req   (fill_req),
    .fill_addr  (fill_addr),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .shift_in   (shift_in),
    .word_out   (word_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then model the downstream shift register from shift_in/word_out
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (shift_in === 1'b1) begin
      if (shifts < 4) chk("word_out", 128'(word_out), 128'(exp_w[shifts]));
      else chk("shift_overflow", 128'(shifts), 128'd3);
      line = {word_out, line[127:32]};
      shifts++;
    end
    if (fill_done === 1'b1) done_cyc = cyc;
  endtask

  task automatic run_fill(input logic [31:0] addr, input logic [31:0] dbase, input int gd,
                          input int rd, input bit zl, input bit hold, input int abort_after);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF0;
    for (int k = 0; k < 4; k++) exp_w[k] = dbase + 32'(k);
    shifts   = 0;
    line     = '0;
    done_cyc = -1;
    fill_req  = 1'b1;
    fill_addr = addr;
    req_cyc   = cyc;
    tick();
    if (!hold) fill_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < gd; i++) begin
        chk("req_held", 128'(mem_req), 128'd1);
        chk("addr_held", 128'(mem_addr), 128'(base + 32'(4 * k)));
        tick();
      end
      chk("mem_req", 128'(mem_req), 128'd1);
      chk("mem_addr", 128'(mem_addr), 128'(base + 32'(4 * k)));
      chk("busy", 128'(fill_busy), 128'd1);
      mem_gnt = 1'b1;
      if (zl) begin
        mem_rvalid = 1'b1;
        mem_rdata  = exp_w[k];
      end
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!zl) begin
        for (int i = 0; i < rd - 1; i++) begin
          chk("wait_no_req", 128'(mem_req), 128'd0);
          tick();
        end
        chk("wait_no_req", 128'(mem_req), 128'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = exp_w[k];
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_0000;
      end
      last_rv = cyc - 1;
      if (k + 1 == abort_after) begin
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk("rst_busy", 128'(fill_busy), 128'd0);
        chk("rst_done", 128'(fill_done), 128'd0);
        chk("rst_req", 128'(mem_req), 128'd0);
        chk("rst_addr", 128'(mem_addr), 128'd0);
        chk("rst_shift", 128'(shift_in), 128'd0);
        chk("rst_word", 128'(word_out), 128'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_idle", 128'(fill_busy), 128'd0);
        chk("rst_no_done", 128'(done_cyc == -1), 128'd1);
        return;
      end
    end
    chk("drain_not_done", 128'(fill_done), 128'd0);
    tick();
    chk("fill_done", 128'(fill_done), 128'd1);
    chk("done_at_rv_plus2", 128'(done_cyc), 128'(last_rv + 2));
    tick();
    chk("done_pulse_end", 128'(fill_done), 128'd0);
    chk("idle_after_done", 128'(fill_busy), 128'd0);
    fill_req = 1'b0;
    chk("shift_count", 128'(shifts), 128'd4);
    chk("line", line, {exp_w[3], exp_w[2], exp_w[1], exp_w[0]});
    // Request cycle through done cycle, inclusive, for a memory granting immediately
    if (gd == 0 && rd == 1 && !zl) chk("fill_latency", 128'(done_cyc - req_cyc + 1), 128'd11);
  endtask

  initial begin
    Reset      = 1'b0;
    fill_req   = 1'b0;
    fill_addr  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    shifts     = 0;
    line       = '0;
    done_cyc   = -1;
    tick();
    tick();
    chk("reset_busy", 128'(fill_busy), 128'd0);
    chk("reset_done", 128'(fill_done), 128'd0);
    chk("reset_req", 128'(mem_req), 128'd0);
    chk("reset_addr", 128'(mem_addr), 128'd0);
    chk("reset_shift", 128'(shift_in), 128'd0);
    chk("reset_word", 128'(word_out), 128'd0);
    Reset = 1'b1;
    tick();

    // Basic fill
    run_fill(32'h0000_1000, 32'h0000_00A0, 0, 1, 1'b0, 1'b0, 0);
    // Unaligned address
    run_fill(32'h0000_203A, 32'h5555_0010, 0, 1, 1'b0, 1'b0, 0);
    // Back-pressure on grant and read data
    run_fill(32'h0000_4440, 32'hC0DE_0000, 3, 5, 1'b0, 1'b0, 0);
    // Zero-latency memory
    run_fill(32'h0000_5008, 32'h1234_5670, 0, 0, 1'b1, 1'b0, 0);

    // Spurious rvalid while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("idle_rv_shift", 128'(shift_in), 128'd0);
    tick();
    chk("idle_rv_shift2", 128'(shift_in), 128'd0);
    chk("idle_rv_busy", 128'(fill_busy), 128'd0);
    mem_rvalid = 1'b0;

    // fill_req held high for the whole fill
    run_fill(32'h0000_6000, 32'h7700_0000, 1, 2, 1'b0, 1'b1, 0);
    tick();
    chk("held_req_no_refill", 128'(fill_busy), 128'd0);
    chk("held_req_no_shift", 128'(shifts), 128'd4);

    // Reset after beat 1, then a clean fill
    run_fill(32'h0000_7000, 32'h0BAD_0000, 0, 1, 1'b0, 1'b0, 2);
    run_fill(32'h0000_3000, 32'h3300_0000, 0, 1, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_fill_ctrl.md
Name: line_fill_ctrl

Overview:
Upstream feeder for the 128-bit line shift register used on the cache-miss refill path. On a fill request it fetches four consecutive 32-bit words from the word-wide memory port, one outstanding read at a time. Each returned word is presented to the shift register as a registered shift pulse plus data. It signals completion in the cycle the assembled line becomes valid at the shift register output.

Parameters:
LINE_WORDS, 4, words per line; must match the shift register width divided by 32 (128/32).
ADDR_W, 32, byte-address width.

Ports:
Clk  in  1  clock; all logic on the rising edge.
Reset  in  1  synchronous, active-low; Reset==0 at a rising edge resets the block.
fill_req  in  1  request pulse or level; sampled only in IDLE.
fill_addr  in  ADDR_W  byte address of any byte inside the target line.
fill_busy  out  1  high whenever state != IDLE.
fill_done  out  1  one-cycle pulse; assembled line is valid on the shift register output this cycle.
mem_req  out  1  read request; held until granted.
mem_addr  out  ADDR_W  word-aligned read address.
mem_gnt  in  1  request accepted this cycle.
mem_rvalid  in  1  read data valid.
mem_rdata  in  32  read data.
shift_in  out  1  registered shift strobe to the shift register.
word_out  out  32  registered data to the shift register.

Behaviour:
- Reset: state=IDLE, beat=0. All outputs are 0: fill_busy, fill_done, mem_req, mem_addr, shift_in, word_out. A reset mid-fill abandons the transfer; no fill_done is issued and the partial line is discarded.
- Line alignment: base = fill_addr with bits [3:0] cleared (log2(LINE_WORDS*4) bits). Beat k reads base + 4*k, for k = 0..LINE_WORDS-1.
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE: when fill_req=1, latch base and set beat=0, then go to REQ.
- REQ: mem_req=1 and mem_addr=base+4*beat, both stable until mem_gnt.
  - On mem_gnt=1, go to WAIT and drop mem_req on the next cycle.
  - If mem_gnt and mem_rvalid are both 1 in the same cycle, treat it as a granted and completed beat (zero-latency memory).
- WAIT: mem_req=0. On mem_rvalid=1, capture mem_rdata.
  - If beat==LINE_WORDS-1, go to DRAIN.
  - Otherwise increment beat and go to REQ.
- mem_rvalid outside REQ/WAIT is ignored. Wait states of any length in REQ or WAIT are legal; there is no timeout.
- Data path: a beat completing at cycle t gives shift_in=1 and word_out=captured data at t+1, for exactly one cycle. shift_in is 0 otherwise; word_out holds its last value.
- Word order: word 0 is fetched first, so it ends in line bits [31:0] and word 3 ends in [127:96].
- DRAIN: one cycle, covering the final shift pulse. Then go to DONE.
- DONE: fill_done=1 for one cycle, then return to IDLE. The last rvalid at t gives fill_done at t+2.
- Minimum fill time, with grant in the REQ cycle and rvalid on the next cycle: 1 (IDLE accept) + 4*2 + 2 = 11 cycles from fill_req to fill_done.
- fill_req while fill_busy=1 is ignored and is not queued. A new request can be accepted in the cycle after DONE.
- mem_addr wraps modulo 2^ADDR_W; no special case is needed because the line is aligned.

Decomposition:
- Package line_fill_pkg holds:
  - the state enum (IDLE, REQ, WAIT, DRAIN, DONE);
  - WORD_BYTES=4;
  - LINE_WORDS=4;
  - LINE_OFFSET_BITS=4.
- No sub-module: a single FSM with a 2-bit beat counter and base register. The shift register itself is instantiated by the parent.

Test Plan:
- Basic fill: fill_addr=0x0000_1000; grant on first REQ cycle; rvalid one cycle later with data 0xA0,0xA1,0xA2,0xA3 -> mem_addr sequence 0x1000,0x1004,0x1008,0x100C; four shift_in pulses in that data order; fill_done 11 cycles after fill_req; line = 0x000000A3_000000A2_000000A1_000000A0.
- Unaligned address: fill_addr=0x0000_203A -> reads 0x2030..0x203C; same line ordering.
- Back-pressure: mem_gnt delayed 3 cycles and rvalid delayed 5 cycles per beat -> mem_req and mem_addr stable throughout; exactly 4 shift_in pulses; one fill_done.
- Zero-latency memory: mem_gnt and mem_rvalid asserted in the same cycle for all beats -> four beats complete; shift_in and fill_done timing rule still holds (done 2 cycles after last rvalid).
- fill_req held high during a fill, plus spurious mem_rvalid in IDLE -> no second fill starts until after DONE; no extra shift_in.
- Reset (0) asserted after beat 1 -> next cycle all outputs 0 and state IDLE; no fill_done; a subsequent fill from 0x3000 completes normally.
